// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the execute stage and its iterative
// multiply/divide unit:
//   - alu_op_e    : 6-bit ALU operation codes (M-ops occupy 16..19)
//   - OPC_*       : RV32 opcodes the execute stage decodes itself
//   - F3_*        : branch funct3 encodings
//   - md_state_e  : muldiv sequencer states
//   - is_muldiv_op: true for ops serviced by the iterative unit
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [5:0] {
        ALU_ADD    = 6'd0,
        ALU_SUB    = 6'd1,
        ALU_AND    = 6'd2,
        ALU_OR     = 6'd3,
        ALU_XOR    = 6'd4,
        ALU_SLL    = 6'd5,
        ALU_SRL    = 6'd6,
        ALU_SRA    = 6'd7,
        ALU_SLT    = 6'd8,
        ALU_SLTU   = 6'd9,
        ALU_PASS_B = 6'd10,
        ALU_MUL    = 6'd16,
        ALU_MULHU  = 6'd17,
        ALU_DIVU   = 6'd18,
        ALU_REMU   = 6'd19
    } alu_op_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv_op(input alu_op_e op);
        logic r;
        case (op)
            ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative unsigned multiply (shift-add) and restoring divide, one step per
// clock, MD_CYCLES steps per operation.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset (aborts any op)
//   start_i        : an M-op is present in EX (only sampled in IDLE)
//   op_i, a_i, b_i : operation and operands, latched on IDLE->BUSY
//   busy_o         : hold upstream (IDLE with start, or BUSY)
//   done_o         : result valid this cycle (DONE state)
//   result_o       : MUL/MULHU/DIVU/REMU result
// -----------------------------------------------------------------------------
module muldiv_unit
    import pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    alu_op_e         op_q, op_d;
    // opnd_q: multiplicand for MUL*, divisor for DIV*/REM*
    logic [XLEN-1:0] opnd_q, opnd_d;
    // hi_q: upper product / partial remainder; lo_q: multiplier / quotient
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            is_mul_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_shift_s;
    logic [XLEN:0]   div_trial_s;

    // Sequencer next state and one datapath iteration per BUSY cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        is_mul_s    = (op_q == ALU_MUL) || (op_q == ALU_MULHU);
        // Carry out of the add becomes the top bit shifted into hi.
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_q, lo_q[XLEN-1]};
        div_trial_s = div_shift_s - {1'b0, opnd_q};

        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = {CW{1'b0}};
                    op_d    = op_i;
                    hi_d    = {XLEN{1'b0}};
                    if ((op_i == ALU_MUL) || (op_i == ALU_MULHU)) begin
                        opnd_d = a_i;
                        lo_d   = b_i;
                    end else begin
                        opnd_d = b_i;
                        lo_d   = a_i;
                    end
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (is_mul_s) begin
                    hi_d = mul_sum_s[XLEN:1];
                    lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
                end else if (!div_trial_s[XLEN]) begin
                    // Divisor fits: a zero divisor always lands here, giving
                    // all-ones quotient and remainder == dividend.
                    hi_d = div_trial_s[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= MD_IDLE;
            cnt_q   <= {CW{1'b0}};
            op_q    <= ALU_MUL;
            opnd_q  <= {XLEN{1'b0}};
            hi_q    <= {XLEN{1'b0}};
            lo_q    <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Result selection from the finished hi/lo registers
    always_comb begin
        case (op_q)
            ALU_MUL:   result_o = lo_q;
            ALU_MULHU: result_o = hi_q;
            ALU_DIVU:  result_o = lo_q;
            ALU_REMU:  result_o = hi_q;
            default:   result_o = lo_q;
        endcase
    end

    assign busy_o = ((state_q == MD_IDLE) && start_i) || (state_q == MD_BUSY);
    assign done_o = (state_q == MD_DONE);

endmodule

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// RV32 execute stage: operand forwarding, ALU, branch/jump resolution and an
// iterative M-extension subset, feeding the internal EX/MEM register (em_*).
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   de_*                   : decoded instruction from the DE/EX register
//   mw_rd_i/mw_reg_write_i/mw_data_i : MEM/WB writeback for forwarding
//   em_*                   : registered EX/MEM outputs
//   redirect_o/redirect_pc_o : combinational taken branch / jump target
//   stall_o                : hold upstream while an M-op is in flight
// -----------------------------------------------------------------------------
module execute_stage
    import pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] de_pc_i,
    input  logic [6:0]      de_opcode_i,
    input  logic [2:0]      de_funct3_i,
    input  logic            de_alusrc1_i,
    input  logic            de_alusrc2_i,
    input  logic [5:0]      de_alu_op_i,
    input  logic [4:0]      de_rs1_i,
    input  logic [4:0]      de_rs2_i,
    input  logic [4:0]      de_rd_i,
    input  logic [XLEN-1:0] de_read_data1_i,
    input  logic [XLEN-1:0] de_read_data2_i,
    input  logic [XLEN-1:0] de_offset_i,
    input  logic            de_reg_write_i,
    input  logic            de_mem_read_i,
    input  logic            de_mem_write_i,
    input  logic            de_jump_i,
    input  logic [1:0]      de_mem_to_reg_i,
    input  logic [4:0]      mw_rd_i,
    input  logic            mw_reg_write_i,
    input  logic [XLEN-1:0] mw_data_i,
    output logic [XLEN-1:0] em_alu_result_o,
    output logic [XLEN-1:0] em_store_data_o,
    output logic [4:0]      em_rd_o,
    output logic [2:0]      em_funct3_o,
    output logic            em_reg_write_o,
    output logic            em_mem_read_o,
    output logic            em_mem_write_o,
    output logic [1:0]      em_mem_to_reg_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            stall_o
);

    localparam int SHW = $clog2(XLEN);

    alu_op_e         alu_op_s;
    logic [XLEN-1:0] fwd_rs1_s, fwd_rs2_s;
    logic [XLEN-1:0] op_a_s, op_b_s, alu_res_s;
    logic [XLEN-1:0] pc_plus4_s, br_target_s, jalr_sum_s, jalr_target_s;
    logic            is_branch_s, is_jalr_s, is_jump_s, br_taken_s;
    logic            is_mop_s, bubble_s, md_start_s, md_busy_s, md_done_s;
    logic [XLEN-1:0] md_result_s;

    logic [XLEN-1:0] em_alu_result_q, em_alu_result_d;
    logic [XLEN-1:0] em_store_data_q, em_store_data_d;
    logic [4:0]      em_rd_q, em_rd_d;
    logic [2:0]      em_funct3_q, em_funct3_d;
    logic            em_reg_write_q, em_reg_write_d;
    logic            em_mem_read_q, em_mem_read_d;
    logic            em_mem_write_q, em_mem_write_d;
    logic [1:0]      em_mem_to_reg_q, em_mem_to_reg_d;

    assign alu_op_s    = alu_op_e'(de_alu_op_i);
    assign is_branch_s = (de_opcode_i == OPC_BRANCH);
    assign is_jalr_s   = (de_opcode_i == OPC_JALR);
    assign is_jump_s   = de_jump_i || (de_opcode_i == OPC_JAL) || is_jalr_s;
    assign is_mop_s    = is_muldiv_op(alu_op_s);
    assign bubble_s    = !de_reg_write_i && !de_mem_read_i && !de_mem_write_i
                         && !is_branch_s && !is_jump_s;
    assign md_start_s  = is_mop_s && !bubble_s;

    // rs1 forwarding: EX/MEM beats MEM/WB, x0 never forwarded
    always_comb begin
        if (em_reg_write_q && (em_rd_q == de_rs1_i) && (de_rs1_i != 5'd0)) begin
            fwd_rs1_s = em_alu_result_q;
        end else if (mw_reg_write_i && (mw_rd_i == de_rs1_i) && (de_rs1_i != 5'd0)) begin
            fwd_rs1_s = mw_data_i;
        end else begin
            fwd_rs1_s = de_read_data1_i;
        end
    end

    // rs2 forwarding: same priority as rs1
    always_comb begin
        if (em_reg_write_q && (em_rd_q == de_rs2_i) && (de_rs2_i != 5'd0)) begin
            fwd_rs2_s = em_alu_result_q;
        end else if (mw_reg_write_i && (mw_rd_i == de_rs2_i) && (de_rs2_i != 5'd0)) begin
            fwd_rs2_s = mw_data_i;
        end else begin
            fwd_rs2_s = de_read_data2_i;
        end
    end

    assign op_a_s = de_alusrc1_i ? de_pc_i     : fwd_rs1_s;
    assign op_b_s = de_alusrc2_i ? de_offset_i : fwd_rs2_s;

    // Single-cycle ALU
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (alu_op_s)
            ALU_ADD:    alu_res_s = op_a_s + op_b_s;
            ALU_SUB:    alu_res_s = op_a_s - op_b_s;
            ALU_AND:    alu_res_s = op_a_s & op_b_s;
            ALU_OR:     alu_res_s = op_a_s | op_b_s;
            ALU_XOR:    alu_res_s = op_a_s ^ op_b_s;
            ALU_SLL:    alu_res_s = op_a_s << op_b_s[SHW-1:0];
            ALU_SRL:    alu_res_s = op_a_s >> op_b_s[SHW-1:0];
            ALU_SRA:    alu_res_s = $signed(op_a_s) >>> op_b_s[SHW-1:0];
            ALU_SLT:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            ALU_SLTU:   alu_res_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            ALU_PASS_B: alu_res_s = op_b_s;
            default:    alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Branch condition on forwarded register values (not on ALU operands)
    always_comb begin
        br_taken_s = 1'b0;
        if (is_branch_s) begin
            case (de_funct3_i)
                F3_BEQ:  br_taken_s = (fwd_rs1_s == fwd_rs2_s);
                F3_BNE:  br_taken_s = (fwd_rs1_s != fwd_rs2_s);
                F3_BLT:  br_taken_s = ($signed(fwd_rs1_s) <  $signed(fwd_rs2_s));
                F3_BGE:  br_taken_s = ($signed(fwd_rs1_s) >= $signed(fwd_rs2_s));
                F3_BLTU: br_taken_s = (fwd_rs1_s <  fwd_rs2_s);
                F3_BGEU: br_taken_s = (fwd_rs1_s >= fwd_rs2_s);
                default: br_taken_s = 1'b0;
            endcase
        end else begin
            br_taken_s = 1'b0;
        end
    end

    assign pc_plus4_s    = de_pc_i + {{(XLEN-3){1'b0}}, 3'd4};
    assign br_target_s   = de_pc_i + de_offset_i;
    assign jalr_sum_s    = fwd_rs1_s + de_offset_i;
    assign jalr_target_s = jalr_sum_s & {{(XLEN-1){1'b1}}, 1'b0};

    assign redirect_o    = !md_busy_s && (br_taken_s || is_jump_s);
    assign redirect_pc_o = is_jalr_s ? jalr_target_s : br_target_s;
    assign stall_o       = md_busy_s;

    muldiv_unit #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (md_start_s),
        .op_i     (alu_op_s),
        .a_i      (fwd_rs1_s),
        .b_i      (fwd_rs2_s),
        .busy_o   (md_busy_s),
        .done_o   (md_done_s),
        .result_o (md_result_s)
    );

    // EX/MEM next state: bubble while stalled (rd and data held)
    always_comb begin
        em_alu_result_d = em_alu_result_q;
        em_store_data_d = em_store_data_q;
        em_rd_d         = em_rd_q;
        em_funct3_d     = em_funct3_q;
        em_reg_write_d  = em_reg_write_q;
        em_mem_read_d   = em_mem_read_q;
        em_mem_write_d  = em_mem_write_q;
        em_mem_to_reg_d = em_mem_to_reg_q;
        if (md_busy_s) begin
            em_reg_write_d = 1'b0;
            em_mem_read_d  = 1'b0;
            em_mem_write_d = 1'b0;
        end else begin
            em_alu_result_d = md_done_s ? md_result_s
                            : (is_jump_s ? pc_plus4_s : alu_res_s);
            em_store_data_d = fwd_rs2_s;
            em_rd_d         = de_rd_i;
            em_funct3_d     = de_funct3_i;
            em_reg_write_d  = de_reg_write_i;
            em_mem_read_d   = de_mem_read_i;
            em_mem_write_d  = de_mem_write_i;
            em_mem_to_reg_d = de_mem_to_reg_i;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            em_alu_result_q <= {XLEN{1'b0}};
            em_store_data_q <= {XLEN{1'b0}};
            em_rd_q         <= 5'd0;
            em_funct3_q     <= 3'd0;
            em_reg_write_q  <= 1'b0;
            em_mem_read_q   <= 1'b0;
            em_mem_write_q  <= 1'b0;
            em_mem_to_reg_q <= 2'd0;
        end else begin
            em_alu_result_q <= em_alu_result_d;
            em_store_data_q <= em_store_data_d;
            em_rd_q         <= em_rd_d;
            em_funct3_q     <= em_funct3_d;
            em_reg_write_q  <= em_reg_write_d;
            em_mem_read_q   <= em_mem_read_d;
            em_mem_write_q  <= em_mem_write_d;
            em_mem_to_reg_q <= em_mem_to_reg_d;
        end
    end

    assign em_alu_result_o = em_alu_result_q;
    assign em_store_data_o = em_store_data_q;
    assign em_rd_o         = em_rd_q;
    assign em_funct3_o     = em_funct3_q;
    assign em_reg_write_o  = em_reg_write_q;
    assign em_mem_read_o   = em_mem_read_q;
    assign em_mem_write_o  = em_mem_write_q;
    assign em_mem_to_reg_o = em_mem_to_reg_q;

endmodule
